// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit: operation encoding and its width.
package logic_unit_pkg;

  localparam int LOGIC_OP_W = 3;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } logic_op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational evaluator for the eight bitwise operations; no state, no carries.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic_op_e          op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_ANDN: result = a & ~b;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit. Define LOGIC_UNIT_FLAGS_EN to
// add the registered out_zero / out_parity result flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOGIC_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic                  out_zero,
  output logic                  out_parity,
`endif
  output logic [WIDTH-1:0]      out_result
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high.
  // Producers keep valid/payload until the transfer; ready may depend on the
  // consumer's ready combinationally (in_ready follows out_ready the same cycle).

  logic             s1_valid;
  logic_op_e        s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic [WIDTH-1:0] core_result;
  logic             s1_load;
  logic             s2_load;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= logic_op_e'(in_op);
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_result <= core_result;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic s2_zero;
  logic s2_parity;

  // Flags travel with the result so they share its stall behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
    end else if (s2_load && s1_valid) begin
      s2_zero   <= ~|core_result;
      s2_parity <= ^core_result;
    end
  end

  assign out_zero   = s2_zero;
  assign out_parity = s2_parity;
`endif

  assign out_valid  = s2_valid;
  assign out_result = s2_result;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: the next-generation replacement for the single-function combinational AND in the ALU datapath. Performs one of eight bitwise operations selected per transaction, on WIDTH-bit operands, through a two-stage registered pipeline with valid/ready flow control. It sits between the ALU operand-issue stage and the ALU result mux, and sustains one operation per clock under full back-pressure support.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction offered
- in_ready  output  1  unit can accept this cycle
- in_op  input  3  operation select (logic_op_e)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result transaction offered
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  operation result
- out_zero  output  1  result == 0 (LOGIC_UNIT_FLAGS_EN only)
- out_parity  output  1  XOR-reduce of result (LOGIC_UNIT_FLAGS_EN only)

## Operation
- Ops (in_op encoding): 0 AND a&b; 1 OR a|b; 2 XOR a^b; 3 NAND ~(a&b); 4 NOR ~(a|b); 5 XNOR ~(a^b); 6 ANDN a&~b; 7 PASS a.
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- Stage 1 (S1): registers in_a, in_b, in_op, plus s1_valid.
- Stage 2 (S2): computes op on S1 contents, registers result (and flags), plus s2_valid; out_valid = s2_valid.
- Stage advance: S2 loads when !s2_valid or out_ready; S1 loads when !s1_valid or S2 loads. in_ready = !s1_valid | s2_load (combinational from out_ready; no bubble at full throughput).
- Stage holds contents unchanged while stalled; out_result stable while out_valid & !out_ready.
- Inputs ignored when in_valid low; data registers may be left unchanged when valid not loaded.
- Results emerge strictly in acceptance order; no reordering, no dropping.

## Timing
- Reset (async assert, sync-deassert externally): s1_valid=0, s2_valid=0, all data/flag registers 0 → out_valid=0, out_result=0, out_zero=0, out_parity=0, in_ready=1.
- Latency: transaction accepted at edge N appears on out_valid after edge N+1 (2 edges, first observable cycle after 2nd edge).
- Throughput: 1 transaction/cycle with out_ready held high.
- Full: both stages valid and out_ready=0 → in_ready=0; releasing out_ready for one cycle frees exactly one slot, in_ready=1 that same cycle.
- Simultaneous accept and emit when full: legal, occupancy unchanged.
- Empty pipeline with out_ready=0: accepts up to 2 transactions, then stalls.
- Reset mid-operation: all in-flight transactions discarded immediately, out_valid drops asynchronously.
- Width: all ops bitwise, no carries; results exactly WIDTH bits, no extension.

## Configuration
- LOGIC_UNIT_FLAGS_EN defined: out_zero and out_parity ports exist, registered in S2 alongside out_result, same valid/stall behaviour.
- Not defined: ports absent, flag logic and registers not built; all other behaviour identical.

## Structure
- Package logic_unit_pkg: logic_op_e enum (3-bit, encodings above), LOGIC_OP_W constant.
- Sub-module logic_unit_core: purely combinational op decoder/evaluator (WIDTH, op, a, b → result), instantiated between S1 and S2; the pipeline/handshake lives in logic_unit_pipe.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 in flight → out_valid=0 immediately, out_result=0, in_ready=1 after release.
- All ops, WIDTH=32, a=0xF0F0_1234, b=0x0FF0_FFFF, out_ready=1 → AND 0x00F0_1234, OR 0xFFF0_FFFF, XOR 0xFF00_EDCB, NAND 0xFF0F_EDCB, NOR 0x000F_0000, XNOR 0x00FF_1234, ANDN 0xF000_0000, PASS 0xF0F0_1234, each 2 cycles after acceptance.
- Streaming: 100 random back-to-back ops, out_ready=1 → 100 results in order, one per cycle, in_ready never low.
- Back-pressure: out_ready=0 while offering 3 ops → first 2 accepted, in_ready=0 on 3rd; toggle out_ready randomly → no loss/duplication, out_result stable while stalled.
- Flags (LOGIC_UNIT_FLAGS_EN): XOR a=b=0xDEAD_BEEF → result 0, out_zero=1, out_parity=0; PASS a=0x0000_0007 → out_zero=0, out_parity=1.
- WIDTH=1 and WIDTH=64 builds: AND/NOR truth table and PASS of 0x8000_0000_0000_0001 correct.
